// File: rtl/pulse_edge_detector_multi_pkg.sv
// Shared mode encodings and sizing helper
// for the multi-channel pulse edge detector.
package pulse_edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_POS  = 2'b01;
  localparam logic [1:0] EDGE_NEG  = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Never returns less than 1 so a counter always has a bit.
  function automatic int filt_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pulse_edge_detector_multi_if.sv
// Bundle of pulse inputs, controls and
// detector outputs for all channels.
interface pulse_edge_detector_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  import pulse_edge_pkg::*;

  logic [CH-1:0]       i_pulse;
  logic [2*CH-1:0]     i_mode;
  logic [CH-1:0]       i_clr;
  logic [CH-1:0]       o_edge;
  logic [CH-1:0]       o_level;
  logic [CH*CNT_W-1:0] o_count;
  logic [CH-1:0]       o_sticky;
  logic                o_irq;

  modport master (
    output i_pulse,
    output i_mode,
    output i_clr,
    input  o_edge,
    input  o_level,
    input  o_count,
    input  o_sticky,
    input  o_irq
  );

  modport slave (
    input  i_pulse,
    input  i_mode,
    input  i_clr,
    output o_edge,
    output o_level,
    output o_count,
    output o_sticky,
    output o_irq
  );

endinterface

// File: rtl/pulse_edge_detector_multi_channel.sv
// One channel: synchroniser, glitch filter,
// edge detect, saturating counter, sticky.
module pulse_edge_channel
  import pulse_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             strobe,
  output logic             level,
  output logic [CNT_W-1:0] count,
  output logic             sticky
);

  localparam int FW = filt_clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [FW-1:0]          fcnt;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  logic                   fall;
  logic                   hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse};
    end
  end

  // A new level must be seen FILT_LEN samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
      if (sync[SYNC_STAGES-1] == lvl) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILT_LEN - 1)) begin
        fcnt <= '0;
        lvl  <= ~lvl;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign rise   = lvl & ~lvl_d;
  assign fall   = ~lvl & lvl_d;
  assign hit    = (mode[0] & rise) | (mode[1] & fall);
  assign strobe = hit;
  assign level  = lvl;

  // A clear colliding with an edge keeps that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      unique case (1'b1)
        clr & hit: begin
          count  <= CNT_W'(1);
          sticky <= 1'b1;
        end
        clr & ~hit: begin
          count  <= '0;
          sticky <= 1'b0;
        end
        ~clr & hit: begin
          if (count != '1) count <= count + CNT_W'(1);
          sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pulse_edge_detector_multi.sv
// Multi-channel pulse edge detector with
// per-channel mode and OR-reduced interrupt.
module pulse_edge_detector_multi
  import pulse_edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  pulse_edge_detector_multi_if.slave bus
);

  logic [CH-1:0]       strobe;
  logic [CH-1:0]       level;
  logic [CH*CNT_W-1:0] count;
  logic [CH-1:0]       sticky;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pulse_edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .pulse  (bus.i_pulse[c]),
      .mode   (bus.i_mode[2*c +: 2]),
      .clr    (bus.i_clr[c]),
      .strobe (strobe[c]),
      .level  (level[c]),
      .count  (count[c*CNT_W +: CNT_W]),
      .sticky (sticky[c])
    );
  end

  assign bus.o_edge   = strobe;
  assign bus.o_level  = level;
  assign bus.o_count  = count;
  assign bus.o_sticky = sticky;
  assign bus.o_irq    = |sticky;

endmodule

// File: tb/tb_pulse_edge_detector_multi.sv
// Directed bench for pulse_edge_detector_multi
// with a second narrow-counter instance.
module tb_pulse_edge_detector_multi;
  import pulse_edge_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_edge_detector_multi_if #(.CH(4), .CNT_W(8)) bus ();
  pulse_edge_detector_multi_if #(.CH(1), .CNT_W(2)) sbus ();

  pulse_edge_detector_multi #(
    .CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pulse_edge_detector_multi #(
    .CH(1), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(2)
  ) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] sat_exp [6];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    bus.i_pulse  = '0;
    bus.i_mode   = '0;
    bus.i_clr    = '0;
    sbus.i_pulse = '0;
    sbus.i_mode  = EDGE_BOTH;
    sbus.i_clr   = '0;

    // reset state
    step(2);
    chk("rst_edge", bus.o_edge, 0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_count", bus.o_count, 0);
    chk("rst_sticky", bus.o_sticky, 0);
    chk("rst_irq", bus.o_irq, 0);
    rst_n = 1'b1;
    bus.i_mode = {EDGE_OFF, EDGE_NEG, EDGE_POS, EDGE_BOTH};
    step(2);

    // all channels see the same 20-cycle pulse
    bus.i_pulse = 4'hF;
    step(4);
    chk("rise_pre_edge", bus.o_edge, 0);
    chk("rise_pre_level", bus.o_level, 0);
    step(1);
    chk("rise_edge", bus.o_edge, 4'b0011);
    chk("rise_level", bus.o_level, 4'hF);
    step(1);
    chk("rise_post_edge", bus.o_edge, 0);
    chk("rise_count", bus.o_count, 32'h0000_0101);
    chk("rise_sticky", bus.o_sticky, 4'b0011);
    chk("rise_irq", bus.o_irq, 1);
    step(14);
    bus.i_pulse = 4'h0;
    step(4);
    chk("fall_pre_edge", bus.o_edge, 0);
    chk("fall_pre_level", bus.o_level, 4'hF);
    step(1);
    chk("fall_edge", bus.o_edge, 4'b0101);
    chk("fall_level", bus.o_level, 0);
    step(1);
    chk("fall_post_edge", bus.o_edge, 0);
    chk("fall_count", bus.o_count, 32'h0001_0102);
    chk("fall_sticky", bus.o_sticky, 4'b0111);
    chk("fall_irq", bus.o_irq, 1);

    // clear alone
    bus.i_clr = 4'hF;
    step(1);
    bus.i_clr = 4'h0;
    chk("clr_count", bus.o_count, 0);
    chk("clr_sticky", bus.o_sticky, 0);
    chk("clr_irq", bus.o_irq, 0);
    step(3);

    // 1-cycle glitch
    bus.i_pulse[0] = 1'b1;
    step(1);
    bus.i_pulse[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("g1_edge", bus.o_edge[0], 0);
      chk("g1_level", bus.o_level[0], 0);
    end

    // 2-cycle glitch
    bus.i_pulse[0] = 1'b1;
    step(2);
    bus.i_pulse[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("g2_edge", bus.o_edge[0], 0);
      chk("g2_level", bus.o_level[0], 0);
    end
    chk("g2_count", bus.o_count[7:0], 0);

    // 3-cycle pulse is accepted both ways
    bus.i_pulse[0] = 1'b1;
    step(3);
    bus.i_pulse[0] = 1'b0;
    step(1);
    chk("p3_pre_edge", bus.o_edge[0], 0);
    step(1);
    chk("p3_rise_edge", bus.o_edge[0], 1);
    chk("p3_rise_level", bus.o_level[0], 1);
    step(1);
    chk("p3_mid_edge", bus.o_edge[0], 0);
    chk("p3_mid_count", bus.o_count[7:0], 1);
    step(1);
    chk("p3_mid2_edge", bus.o_edge[0], 0);
    step(1);
    chk("p3_fall_edge", bus.o_edge[0], 1);
    chk("p3_fall_level", bus.o_level[0], 0);
    step(1);
    chk("p3_count", bus.o_count[7:0], 2);
    step(2);

    // clear coincident with a qualified edge
    bus.i_pulse[0] = 1'b1;
    step(5);
    chk("cq_edge", bus.o_edge[0], 1);
    bus.i_clr[0] = 1'b1;
    step(1);
    bus.i_clr[0] = 1'b0;
    chk("cq_count", bus.o_count[7:0], 1);
    chk("cq_sticky", bus.o_sticky[0], 1);

    // saturation on the 2-bit counter
    chk("sat_init", sbus.o_count, 0);
    for (int i = 0; i < 6; i++) begin
      sbus.i_pulse[0] = ~sbus.i_pulse[0];
      step(6);
      chk("sat_count", sbus.o_count, sat_exp[i]);
    end

    // async reset with filter counter at 2
    bus.i_pulse[0] = 1'b0;
    step(8);
    bus.i_pulse[0] = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("arst_edge", bus.o_edge, 0);
    chk("arst_level", bus.o_level, 0);
    chk("arst_count", bus.o_count, 0);
    chk("arst_sticky", bus.o_sticky, 0);
    chk("arst_irq", bus.o_irq, 0);
    step(1);
    rst_n = 1'b1;
    step(4);
    chk("arst_pre_edge", bus.o_edge, 0);
    step(1);
    chk("arst_rise_edge", bus.o_edge, 4'b0001);
    step(1);
    chk("arst_post_edge", bus.o_edge, 0);
    chk("arst_count1", bus.o_count, 32'h0000_0001);
    chk("arst_irq1", bus.o_irq, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_edge_detector_multi.md
# pulse_edge_detector_multi

Parametrised multi-channel successor to the single-bit pulse posedge/negedge/bothedge detectors. Each channel synchronises an asynchronous pulse input, rejects glitches shorter than a programmable stability window, and detects rising, falling or both edges according to a per-channel runtime mode. Each channel also keeps a saturating edge counter and a sticky flag with clear, and the block raises one OR-reduced interrupt. It sits between raw external/cross-domain pulse sources and the control logic that polls or is interrupted by them.

## Interface
- CH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flip-flops per channel (≥2)
- FILT_LEN, 3: consecutive cycles a new synchronised level must hold before it is accepted (≥1)
- CNT_W, 8: width of each per-channel edge counter (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_pulse  in  CH  asynchronous pulse inputs, bit c = channel c
- i_mode  in  2*CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 posedge, 10 negedge, 11 bothedge
- i_clr  in  CH  synchronous per-channel clear of counter and sticky flag
- o_edge  out  CH  one-cycle edge strobe per channel, qualified by mode
- o_level  out  CH  filtered, synchronised level per channel
- o_count  out  CH*CNT_W  saturating edge count, bits [c*CNT_W +: CNT_W]
- o_sticky  out  CH  set on qualified edge, held until i_clr
- o_irq  out  1  OR of all o_sticky bits

## Operation
- Reset: the synchroniser chain, filter level, filter counter, o_edge, o_level, o_count, o_sticky and o_irq are all 0.
- Synchroniser: SYNC_STAGES-deep shift of i_pulse[c]. Only the last stage feeds the filter.
- Filter:
  - Holds level L and a counter of width clog2(FILT_LEN+1).
  - On each edge where sync ≠ L, the counter increments. When it reaches FILT_LEN, L flips and the counter clears.
  - Any cycle with sync == L clears the counter, so the run must be consecutive.
  - FILT_LEN=1 accepts a change after a single sampled cycle.
- Raw edge: rise = L & ~L_d, fall = ~L & L_d, where L_d is L delayed one cycle.
- Qualified edge: o_edge[c] = (mode bit0 & rise) | (mode bit1 & fall).
- Mode 00 gates o_edge, the counter and the sticky flag. o_level keeps tracking in every mode.
- Mode changes take effect in the cycle they are presented. No internal mode register.
- Counter: +1 on each qualified edge and saturates at 2^CNT_W−1; no wrap-around.
- Sticky flag: set on a qualified edge.
- i_clr[c]:
  - Alone: the counter goes to 0 and sticky to 0 on the next edge.
  - With a qualified edge in the same cycle: the counter loads 1 and sticky stays 1, so the edge is never lost.
- Channels are fully independent. Simultaneous edges on several channels are each counted.
- Reset release with i_pulse already high: L rises after the normal latency and produces a rising edge. This is intended.

## Timing
- Latency: a level change first sampled at edge k appears on o_level after edge k+SYNC_STAGES+FILT_LEN−1. o_edge is high for exactly the cycle following that edge. Defaults: 4 edges to o_level, o_edge in cycle 5.
- Minimum accepted pulse width: SYNC_STAGES-independent, ≥FILT_LEN consecutive samples. Shorter pulses produce no o_edge and no change to o_level.
- Edge spacing: o_edge can assert at most once per FILT_LEN cycles per channel.
- o_count and o_sticky update on the same edge that ends the o_edge cycle. o_irq is combinational from o_sticky, with zero extra latency.
- Asynchronous reset mid-operation clears all state immediately. The filter restarts from L=0.

## Structure
- Package pulse_edge_pkg holds:
  - mode constants EDGE_OFF=2'b00, EDGE_POS=2'b01, EDGE_NEG=2'b10, EDGE_BOTH=2'b11
  - a clog2 helper for the filter counter width
- Sub-module pulse_edge_channel contains the synchroniser, filter, edge detect, counter and sticky logic for one channel, with parameters SYNC_STAGES, FILT_LEN and CNT_W.
- The top level instantiates pulse_edge_channel CH times via generate and OR-reduces o_sticky into o_irq.

## Test plan
- Defaults, ch0 mode 11, i_pulse[0] high for 20 cycles then low: two o_edge strobes each 1 cycle wide, 5 cycles after each transition; o_count[0]=2, o_sticky[0]=1, o_irq=1.
- Glitch rejection, FILT_LEN=3: pulses 1 and 2 cycles wide produce no o_edge and o_level stays 0; a 3-cycle pulse produces one rise and one fall.
- Mode coverage on ch1..ch3 (01, 10, 00) with the same stimulus: rising-only count=1, falling-only count=1, off count=0 while o_level still toggles.
- Saturation with CNT_W=2, mode 11, 6 clean transitions: count sequence 1,2,3,3,3,3.
- Clear collisions:
  - i_clr alone: count 0 and sticky 0 next cycle.
  - i_clr coincident with a qualified edge: count 1 and sticky 1.
- rst_n pulsed low mid-filter (counter at 2): all outputs 0 immediately; after release with input still high, a single rising o_edge follows at the nominal latency.
